cnt_reload: RTL and testbench
=============================

Name: cnt_reload

Overview:
Parametrised successor to the fixed 7-bit prescaler counter. It is an up-counter preloaded with 2^WIDTH − n·STEP, so each period is exactly n·STEP enabled cycles. It emits a carry-out on the terminal enabled cycle, then either auto-reloads or stops in one-shot mode. It sits between the controller FSM and the datapath as the programmable-period timer for multi-stage shift/accumulate sequences.

Parameters:
WIDTH, 7, counter width; natural period is 2^WIDTH.
N_W, 4, width of the period selector n.
STEP, 8, period granularity; preload = 2^WIDTH − n·STEP.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
clr  in  1  synchronous clear to IDLE, highest priority
load  in  1  load preload, enter RUN (Q-equivalent)
mode  in  1  0 = auto-reload, 1 = one-shot; sampled only on load
cen  in  1  count enable
n  in  N_W  period selector, sampled on load
cnt  out  WIDTH  current count
co  out  1  combinational carry-out on the terminal enabled cycle
done  out  1  sticky; one-shot period completed
busy  out  1  state == RUN
cfg_err  out  1  registered; last load had n·STEP > 2^WIDTH

Behaviour:
- Reset (rst=0, async): cnt=0, state=IDLE, mode_q=0, done=0, cfg_err=0. Hence co=0 and busy=0.
- States: IDLE, RUN, DONE. The state enum lives in the package.
- Priority per clock edge: clr > load > cen.
- clr=1: cnt<=0, state<=IDLE, done<=0. cfg_err holds its value.
- load=1 (clr=0), in any state:
  - cnt<=preload, mode_q<=mode, state<=RUN, done<=0.
  - cfg_err <= (n·STEP > 2^WIDTH).
- Preload arithmetic: compute in WIDTH+N_W+1 bits, preload = (2^WIDTH − n·STEP) mod 2^WIDTH.
  - n=0 gives preload 0, period 2^WIDTH.
  - n·STEP = 2^WIDTH also gives preload 0; this is legal.
  - If n·STEP > 2^WIDTH, preload is forced to 0 and cfg_err is set.
- RUN, cen=1, cnt != all-ones: cnt<=cnt+1.
- RUN, cen=1, cnt == all-ones: the terminal cycle.
  - co=1 in that same cycle.
  - mode_q=0: cnt<=preload_q (stored preload), remain in RUN. The next period is unbroken.
  - mode_q=1: cnt<=0, state<=DONE, done<=1.
- RUN, cen=0: hold.
- IDLE and DONE: cen is ignored, cnt holds, co=0. DONE exits only on load, clr or reset.
- co definition: co = (state==RUN) & cen & (&cnt) & ~load & ~clr. A load or clr in the terminal cycle suppresses co.
- n and mode changes while running have no effect until the next load.
- Reset mid-run aborts immediately; there is no co, and done is cleared.
- Period invariant: the first co arrives after exactly P = n·STEP enabled cycles (2^WIDTH when n=0) following load. In auto mode each later co also follows P enabled cycles.

Decomposition:
- Package cnt_pkg: state_e enum {IDLE, RUN, DONE}, mode_e enum {AUTO=0, ONESHOT=1}, and a preload calculation function.
- One sub-module, cnt_preload, is natural: combinational computation of preload and cfg_err from n, WIDTH and STEP.
- cnt_reload registers preload_q and contains the FSM and counter.

Test Plan:
1. Auto mode, defaults, n=4, load, then cen held high:
   - cnt=96 after load.
   - co high on the 32nd enabled cycle (cnt=127); cnt returns to 96.
   - Second co 32 cycles later; busy stays 1.
2. One-shot, n=2:
   - co on the 16th enabled cycle.
   - Next edge: cnt=0, done=1, busy=0.
   - 20 further cen cycles give no co and cnt stays 0.
3. n=0, auto mode: preload 0; co every 128 enabled cycles. Toggle cen 50% and confirm the count of enabled cycles between co pulses is exactly 128.
4. STEP=16 instance:
   - n=8: preload 0, cfg_err=0.
   - n=9: cfg_err=1, preload 0.
   - A following valid load with n=1 clears cfg_err and gives preload 112.
5. Priority and collision:
   - At cnt=127 with cen=1, assert load with n=3: co=0 and cnt=104.
   - Repeat with clr: co=0, cnt=0, IDLE.
6. Mid-run reset: n=4, after 10 enables pull rst low between clock edges. Outputs clear immediately (cnt=0, busy=0, done=0), and no co occurs after release until a new load.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared types and preload arithmetic for the reloadable period counter.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    AUTO    = 1'b0,
    ONESHOT = 1'b1
  } mode_e;

  // Preload so that the counter wraps after exactly prod enabled cycles.
  // An out-of-range product (beyond one natural period) collapses to 0.
  function automatic logic [63:0] calc_preload(input int unsigned width,
                                               input logic [63:0] prod);
    logic [63:0] full;
    full = 64'd1 << width;
    if (prod > full) return 64'd0;
    return (full - prod) & (full - 64'd1);
  endfunction

endpackage

// File: rtl/cnt_preload.sv
// Combinational preload and range check for the period selector n.
module cnt_preload
  import cnt_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int N_W   = 4,
  parameter int STEP  = 8
) (
  input  logic [N_W-1:0]   n,
  output logic [WIDTH-1:0] preload,
  output logic             cfg_err
);

  localparam int PW = WIDTH + N_W + 1;

  logic [PW-1:0] prod;
  logic [PW-1:0] full;
  logic [63:0]   pre_wide;

  assign prod     = PW'(n) * PW'(STEP);
  assign full     = PW'(1) << WIDTH;
  assign cfg_err  = (prod > full);
  assign pre_wide = calc_preload(WIDTH, 64'(prod));
  assign preload  = pre_wide[WIDTH-1:0];

endmodule

// File: rtl/cnt_reload.sv
// Programmable-period up-counter with carry-out, auto-reload or one-shot.
// state | meaning
// IDLE  | cleared or reset; counter parked at 0, cen ignored
// RUN   | counting enabled cycles toward all-ones
// DONE  | one-shot period finished; waits for load or clr
module cnt_reload
  import cnt_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int N_W   = 4,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             mode,
  input  logic             cen,
  input  logic [N_W-1:0]   n,
  output logic [WIDTH-1:0] cnt,
  output logic             co,
  output logic             done,
  output logic             busy,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] preload_q, preload_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] preload;
  logic             preload_err;

  cnt_preload #(
    .WIDTH (WIDTH),
    .N_W   (N_W),
    .STEP  (STEP)
  ) u_preload (
    .n       (n),
    .preload (preload),
    .cfg_err (preload_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= AUTO;
      cnt_q     <= '0;
      preload_q <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      preload_q <= preload_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    preload_d = preload_q;
    done_d    = done_q;
    cfg_err_d = cfg_err_q;
    co        = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (load) begin
      cnt_d     = preload;
      preload_d = preload;
      mode_d    = mode_e'(mode);
      state_d   = RUN;
      done_d    = 1'b0;
      cfg_err_d = preload_err;
    end else if (state_q == RUN && cen) begin
      if (&cnt_q) begin
        co = 1'b1;
        // Auto mode reloads the stored preload so the next period is unbroken.
        if (mode_q == AUTO) begin
          cnt_d = preload_q;
        end else begin
          cnt_d   = '0;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  assign cnt     = cnt_q;
  assign done    = done_q;
  assign busy    = (state_q == RUN);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_cnt_reload.sv
// Randomized self-checking bench for cnt_reload against a period-level model.
module tb_cnt_reload;

  localparam int W    = 7;
  localparam int NW   = 4;
  localparam int STP  = 8;
  localparam int NATP = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr, load, mode, cen;
  logic [NW-1:0] n;
  logic [W-1:0]  cnt, cnt16;
  logic          co, done, busy, cfg_err;
  logic          co16, done16, busy16, cfg_err16;

  int vectors = 0;
  int miscompares = 0;

  // Model: remaining enabled cycles until the next carry, not counter bits.
  int m_state;  // 0 idle, 1 run, 2 done
  int m_rem, m_per;
  bit m_one, m_done, m_err;

  always #5 clk = ~clk;

  cnt_reload #(.WIDTH(W), .N_W(NW), .STEP(STP)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .mode(mode), .cen(cen), .n(n),
    .cnt(cnt), .co(co), .done(done), .busy(busy), .cfg_err(cfg_err)
  );

  cnt_reload #(.WIDTH(W), .N_W(NW), .STEP(16)) dut16 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .mode(mode), .cen(cen), .n(n),
    .cnt(cnt16), .co(co16), .done(done16), .busy(busy16), .cfg_err(cfg_err16)
  );

  function automatic logic [W-1:0] m_cnt();
    if (m_state == 1) return W'(NATP - m_rem);
    return '0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_done = 0; m_err = 0; m_rem = NATP; m_per = NATP; m_one = 0;
  endtask

  // Drives one cycle from a negedge, captures co before the edge, advances the model.
  task automatic drive_cycle(input bit l, input bit c, input bit e, input int nn,
                             input bit md, output logic obs_co, output logic exp_co);
    int p;
    load = l; clr = c; cen = e; n = NW'(nn); mode = md;
    #1;
    obs_co = co;
    exp_co = (m_state == 1) && e && (m_rem == 1) && !l && !c;
    @(posedge clk);
    if (c) begin
      m_state = 0; m_done = 0;
    end else if (l) begin
      p = nn * STP;
      m_err = (p > NATP);
      if (nn == 0 || m_err) p = NATP;
      m_per = p; m_rem = p; m_one = md; m_state = 1; m_done = 0;
    end else if (m_state == 1 && e) begin
      if (m_rem == 1) begin
        if (!m_one) m_rem = m_per;
        else begin m_state = 2; m_done = 1; end
      end else m_rem = m_rem - 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++; if (cnt !== '0) begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    vectors++; if (co !== 1'b0) begin miscompares++; $display("FAIL reset_co got=%b exp=0", co); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_auto();
    logic oc, ec;
    int cos = 0;
    drive_cycle(1, 0, 0, 4, 0, oc, ec);
    vectors++; if (cnt !== 7'd96) begin miscompares++; $display("FAIL auto_load_cnt got=%0d exp=96", cnt); end
    for (int i = 1; i <= 70; i++) begin
      drive_cycle(0, 0, 1, $urandom % 16, $urandom % 2, oc, ec);
      if (oc === 1'b1) cos++;
      vectors++; if (oc !== ec) begin miscompares++; $display("FAIL auto_co cyc=%0d got=%b exp=%b", i, oc, ec); end
      vectors++; if (cnt !== m_cnt()) begin miscompares++; $display("FAIL auto_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt()); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL auto_busy cyc=%0d got=%b exp=1", i, busy); end
      if (i == 32 || i == 64) begin
        vectors++; if (oc !== 1'b1 || cnt !== 7'd96) begin miscompares++; $display("FAIL auto_wrap cyc=%0d co=%b cnt=%0d exp co=1 cnt=96", i, oc, cnt); end
      end
    end
    vectors++; if (cos != 2) begin miscompares++; $display("FAIL auto_co_count got=%0d exp=2", cos); end
  endtask

  task automatic test_oneshot();
    logic oc, ec;
    drive_cycle(1, 0, 0, 2, 1, oc, ec);
    for (int i = 1; i <= 36; i++) begin
      drive_cycle(0, 0, 1, $urandom % 16, 0, oc, ec);
      vectors++; if (oc !== ec) begin miscompares++; $display("FAIL oneshot_co cyc=%0d got=%b exp=%b", i, oc, ec); end
      vectors++; if (cnt !== m_cnt()) begin miscompares++; $display("FAIL oneshot_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt()); end
      vectors++; if (done !== m_done || busy !== (m_state == 1)) begin
        miscompares++; $display("FAIL oneshot_flags cyc=%0d done=%b busy=%b exp done=%b busy=%b", i, done, busy, m_done, m_state == 1);
      end
    end
    vectors++; if (done !== 1'b1 || busy !== 1'b0 || cnt !== '0) begin
      miscompares++; $display("FAIL oneshot_end done=%b busy=%b cnt=%0d exp 1 0 0", done, busy, cnt);
    end
  endtask

  task automatic test_n0_random_cen();
    logic oc, ec;
    int en_cnt = 0;
    int cos = 0;
    bit e;
    drive_cycle(1, 0, 0, 0, 0, oc, ec);
    vectors++; if (cnt !== '0) begin miscompares++; $display("FAIL n0_load_cnt got=%0d exp=0", cnt); end
    for (int i = 1; i <= 600; i++) begin
      e = $urandom % 2;
      drive_cycle(0, 0, e, $urandom % 16, $urandom % 2, oc, ec);
      if (e) en_cnt++;
      vectors++; if (oc !== ec) begin miscompares++; $display("FAIL n0_co cyc=%0d got=%b exp=%b", i, oc, ec); end
      vectors++; if (cnt !== m_cnt()) begin miscompares++; $display("FAIL n0_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt()); end
      if (oc === 1'b1) begin
        cos++;
        vectors++; if (en_cnt != NATP) begin miscompares++; $display("FAIL n0_period got=%0d exp=%0d", en_cnt, NATP); end
        en_cnt = 0;
      end
    end
    vectors++; if (cos < 1) begin miscompares++; $display("FAIL n0_co_seen got=%0d exp>=1", cos); end
  endtask

  task automatic test_step16();
    logic oc, ec;
    drive_cycle(1, 0, 0, 8, 0, oc, ec);
    vectors++; if (cnt16 !== '0 || cfg_err16 !== 1'b0) begin miscompares++; $display("FAIL s16_n8 cnt=%0d err=%b exp 0 0", cnt16, cfg_err16); end
    drive_cycle(1, 0, 0, 9, 0, oc, ec);
    vectors++; if (cnt16 !== '0 || cfg_err16 !== 1'b1) begin miscompares++; $display("FAIL s16_n9 cnt=%0d err=%b exp 0 1", cnt16, cfg_err16); end
    vectors++; if (cnt !== m_cnt() || cfg_err !== m_err) begin miscompares++; $display("FAIL s8_n9 cnt=%0d err=%b exp %0d %b", cnt, cfg_err, m_cnt(), m_err); end
    drive_cycle(0, 1, 0, 0, 0, oc, ec);
    vectors++; if (cfg_err16 !== 1'b1) begin miscompares++; $display("FAIL s16_clr_holds_err got=%b exp=1", cfg_err16); end
    drive_cycle(1, 0, 0, 1, 0, oc, ec);
    vectors++; if (cnt16 !== 7'd112 || cfg_err16 !== 1'b0) begin miscompares++; $display("FAIL s16_n1 cnt=%0d err=%b exp 112 0", cnt16, cfg_err16); end
  endtask

  task automatic test_collision();
    logic oc, ec;
    drive_cycle(1, 0, 0, 4, 0, oc, ec);
    for (int i = 0; i < 31; i++) drive_cycle(0, 0, 1, 4, 0, oc, ec);
    vectors++; if (cnt !== 7'd127) begin miscompares++; $display("FAIL coll_pre_cnt got=%0d exp=127", cnt); end
    drive_cycle(1, 0, 1, 3, 0, oc, ec);
    vectors++; if (oc !== 1'b0) begin miscompares++; $display("FAIL coll_load_co got=%b exp=0", oc); end
    vectors++; if (cnt !== 7'd104) begin miscompares++; $display("FAIL coll_load_cnt got=%0d exp=104", cnt); end
    for (int i = 0; i < 23; i++) drive_cycle(0, 0, 1, 3, 0, oc, ec);
    vectors++; if (cnt !== 7'd127) begin miscompares++; $display("FAIL coll_pre2_cnt got=%0d exp=127", cnt); end
    drive_cycle(0, 1, 1, 3, 0, oc, ec);
    vectors++; if (oc !== 1'b0) begin miscompares++; $display("FAIL coll_clr_co got=%b exp=0", oc); end
    vectors++; if (cnt !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL coll_clr_state cnt=%0d busy=%b done=%b exp 0 0 0", cnt, busy, done);
    end
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, 1, 3, 0, oc, ec);
    vectors++; if (cnt !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_ignores_cen cnt=%0d busy=%b exp 0 0", cnt, busy); end
  endtask

  task automatic test_reset_mid();
    logic oc, ec;
    int cos = 0;
    drive_cycle(1, 0, 0, 4, 0, oc, ec);
    for (int i = 0; i < 10; i++) drive_cycle(0, 0, 1, 4, 0, oc, ec);
    #2 rst = 1'b0;
    #1;
    vectors++; if (cnt !== '0 || busy !== 1'b0 || done !== 1'b0 || co !== 1'b0) begin
      miscompares++; $display("FAIL midrst cnt=%0d busy=%b done=%b co=%b exp all 0", cnt, busy, done, co);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(0, 0, 1, 4, 0, oc, ec);
      if (oc !== 1'b0) cos++;
    end
    vectors++; if (cos != 0) begin miscompares++; $display("FAIL midrst_no_co got=%0d exp=0", cos); end
  endtask

  task automatic test_random();
    logic oc, ec;
    int r;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      drive_cycle(r < 4, r >= 98, ($urandom % 4) != 0, $urandom % 4, $urandom % 2, oc, ec);
      vectors++; if (oc !== ec) begin miscompares++; $display("FAIL rnd_co cyc=%0d got=%b exp=%b", i, oc, ec); end
      vectors++; if (cnt !== m_cnt()) begin miscompares++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt()); end
      vectors++; if (done !== m_done || busy !== (m_state == 1) || cfg_err !== m_err) begin
        miscompares++; $display("FAIL rnd_flags cyc=%0d done=%b busy=%b err=%b exp %b %b %b", i, done, busy, cfg_err, m_done, m_state == 1, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; mode = 1'b0; cen = 1'b0; n = '0;
    model_reset();
    @(negedge clk);
    cen = 1'b1;
    @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_auto();
    test_oneshot();
    test_n0_random_cen();
    test_step16();
    test_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
